// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit unsigned adder: operands are captured on start, then added
// LSB first through a registered-carry full adder built from two half adders.

module half_adder (
    input  logic i_a,
    input  logic i_b,
    output logic o_sum,
    output logic o_carry
);
    assign o_sum   = i_a ^ i_b;
    assign o_carry = i_a & i_b;
endmodule

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out
);
    localparam int             CW   = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_result;
    logic [CW-1:0]    r_cnt;
    logic             r_carry;
    logic             r_carry_out;
    logic             r_ready;
    logic             r_busy;
    logic             r_done;

    logic             w_s0;
    logic             w_c0;
    logic             w_sum;
    logic             w_c1;
    logic             w_c_next;
    logic [WIDTH-1:0] w_result_next;

    // Full adder: first half adder combines the operand bits, second folds in the carry.
    half_adder u_ha0 (
        .i_a     (r_a_sh[0]),
        .i_b     (r_b_sh[0]),
        .o_sum   (w_s0),
        .o_carry (w_c0)
    );

    half_adder u_ha1 (
        .i_a     (w_s0),
        .i_b     (r_carry),
        .o_sum   (w_sum),
        .o_carry (w_c1)
    );

    assign w_c_next = w_c0 | w_c1;

    // A one-bit result has no upper slice to shift down, so it takes the sum directly.
    generate
        if (WIDTH == 1) begin : g_res_narrow
            assign w_result_next = w_sum;
        end else begin : g_res_wide
            assign w_result_next = {w_sum, r_result[WIDTH-1:1]};
        end
    endgenerate

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values; blocking here would let later statements see updated state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_a_sh      <= '0;
            r_b_sh      <= '0;
            r_result    <= '0;
            r_cnt       <= '0;
            r_carry     <= 1'b0;
            r_carry_out <= 1'b0;
            r_ready     <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_a_sh  <= op_a;
                        r_b_sh  <= op_b;
                        r_carry <= 1'b0;
                        r_cnt   <= '0;
                        r_ready <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= SHIFT;
                    end
                end
                SHIFT: begin
                    r_result <= w_result_next;
                    r_a_sh   <= r_a_sh >> 1;
                    r_b_sh   <= r_b_sh >> 1;
                    r_carry  <= w_c_next;
                    r_cnt    <= r_cnt + 1'b1;
                    if (r_cnt == LAST) begin
                        r_carry_out <= w_c_next;
                        r_busy      <= 1'b0;
                        r_done      <= 1'b1;
                        r_state     <= DONE;
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_ready <= 1'b1;
                    r_state <= IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_ready <= 1'b1;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign ready     = r_ready;
    assign busy      = r_busy;
    assign done      = r_done;
    assign result    = r_result;
    assign carry_out = r_carry_out;

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder at WIDTH=8, 1 and 16 with hand-computed sums.

module tb_serial_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;

    logic        s8;
    logic [7:0]  a8, b8, res8;
    logic        rdy8, bsy8, dn8, co8;

    logic        s1;
    logic [0:0]  a1, b1, res1;
    logic        rdy1, bsy1, dn1, co1;

    logic        s16;
    logic [15:0] a16, b16, res16;
    logic        rdy16, bsy16, dn16, co16;

    int n_cmp  = 0;
    int n_fail = 0;

    serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(s8), .op_a(a8), .op_b(b8),
        .ready(rdy8), .busy(bsy8), .done(dn8), .result(res8), .carry_out(co8)
    );

    serial_adder #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .start(s1), .op_a(a1), .op_b(b1),
        .ready(rdy1), .busy(bsy1), .done(dn1), .result(res1), .carry_out(co1)
    );

    serial_adder #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .start(s16), .op_a(a16), .op_b(b16),
        .ready(rdy16), .busy(bsy16), .done(dn16), .result(res16), .carry_out(co16)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic get_ready(input int w);
        case (w)
            1:       return rdy1;
            16:      return rdy16;
            default: return rdy8;
        endcase
    endfunction

    function automatic logic get_busy(input int w);
        case (w)
            1:       return bsy1;
            16:      return bsy16;
            default: return bsy8;
        endcase
    endfunction

    function automatic logic get_done(input int w);
        case (w)
            1:       return dn1;
            16:      return dn16;
            default: return dn8;
        endcase
    endfunction

    function automatic logic [15:0] get_result(input int w);
        case (w)
            1:       return {15'd0, res1};
            16:      return res16;
            default: return {8'd0, res8};
        endcase
    endfunction

    function automatic logic get_carry(input int w);
        case (w)
            1:       return co1;
            16:      return co16;
            default: return co8;
        endcase
    endfunction

    task automatic set_in(input int w, input logic st, input logic [15:0] a, input logic [15:0] b);
        case (w)
            1:       begin s1  = st; a1  = a[0:0]; b1  = b[0:0]; end
            16:      begin s16 = st; a16 = a;      b16 = b;      end
            default: begin s8  = st; a8  = a[7:0]; b8  = b[7:0]; end
        endcase
    endtask

    // One addition: accept, then count ticks until done and busy samples along the way.
    task automatic add_op(input int w, input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] exp_r, input logic exp_c, input string tag);
        int  lat    = 0;
        int  busy_n = 0;
        for (int i = 0; i < 40 && !get_ready(w); i++) tick();
        check({tag, "_ready"}, 32'(get_ready(w)), 32'd1);
        set_in(w, 1'b1, a, b);
        tick();
        set_in(w, 1'b0, ~a, ~b);
        for (int i = 0; i < 40; i++) begin
            if (get_done(w)) break;
            if (get_busy(w)) busy_n++;
            tick();
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'(w));
        check({tag, "_busy_cycles"}, 32'(busy_n), 32'(w));
        check({tag, "_result"}, 32'(get_result(w)), 32'(exp_r));
        check({tag, "_carry"}, 32'(get_carry(w)), 32'(exp_c));
        tick();
        check({tag, "_done_pulse"}, 32'(get_done(w)), 32'd0);
        check({tag, "_ready_back"}, 32'(get_ready(w)), 32'd1);
    endtask

    logic [7:0] ha [0:39];
    logic [7:0] hb [0:39];

    initial begin
        int exp_t;
        int dones;

        rst = 1'b1;
        set_in(8, 1'b0, 16'h0, 16'h0);
        set_in(1, 1'b0, 16'h0, 16'h0);
        set_in(16, 1'b0, 16'h0, 16'h0);
        tick();
        tick();
        rst = 1'b0;
        check("reset_ready",  32'(rdy8), 32'd1);
        check("reset_busy",   32'(bsy8), 32'd0);
        check("reset_done",   32'(dn8),  32'd0);
        check("reset_result", 32'(res8), 32'd0);
        check("reset_carry",  32'(co8),  32'd0);
        check("reset_w16_result", 32'(res16), 32'd0);

        add_op(8, 16'h3C, 16'h0F, 16'h4B, 1'b0, "w8_3c_0f");
        add_op(8, 16'hFF, 16'h01, 16'h00, 1'b1, "w8_ff_01");
        add_op(8, 16'hFF, 16'hFF, 16'hFE, 1'b1, "w8_ff_ff");
        add_op(8, 16'h00, 16'h00, 16'h00, 1'b0, "w8_00_00");

        // Start held high; later operands must not disturb the operation in flight.
        dones = 0;
        exp_t = 8;
        for (int t = 0; t < 20; t++) begin
            if (t == 0) begin ha[t] = 8'h12; hb[t] = 8'h34; end
            else        begin ha[t] = 8'h11; hb[t] = 8'h22; end
            s8 = 1'b1; a8 = ha[t]; b8 = hb[t];
            tick();
            if (dn8) begin
                check($sformatf("ign_done_t%0d", t), 32'(t), 32'(exp_t));
                check($sformatf("ign_result_t%0d", t), 32'(res8),
                      (dones == 0) ? 32'h46 : 32'h33);
                dones++;
                exp_t += 10;
            end
        end
        check("ign_done_count", 32'(dones), 32'd2);

        // Back-to-back with operands changing every cycle: accepts land every 10 edges.
        s8 = 1'b0;
        for (int i = 0; i < 40 && !rdy8; i++) tick();
        check("b2b_idle_before", 32'(rdy8), 32'd1);
        dones = 0;
        exp_t = 8;
        for (int t = 0; t < 31; t++) begin
            ha[t] = 8'(t * 7 + 3);
            hb[t] = 8'(t * 13 + 5);
            s8 = 1'b1; a8 = ha[t]; b8 = hb[t];
            tick();
            if (dn8) begin
                check($sformatf("b2b_done_t%0d", t), 32'(t), 32'(exp_t));
                check($sformatf("b2b_result_t%0d", t), 32'(res8),
                      32'(8'(ha[t-8] + hb[t-8])));
                dones++;
                exp_t += 10;
            end
        end
        check("b2b_done_count", 32'(dones), 32'd3);
        s8 = 1'b0;

        // Reset asserted during the 4th SHIFT cycle aborts without a done pulse.
        for (int i = 0; i < 40 && !rdy8; i++) tick();
        s8 = 1'b1; a8 = 8'hAA; b8 = 8'h55;
        tick();
        s8 = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_mid_ready",  32'(rdy8), 32'd1);
        check("rst_mid_busy",   32'(bsy8), 32'd0);
        check("rst_mid_result", 32'(res8), 32'd0);
        check("rst_mid_carry",  32'(co8),  32'd0);
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (dn8) dones++;
        end
        check("rst_mid_no_done", 32'(dones), 32'd0);

        add_op(8, 16'hAA, 16'h55, 16'hFF, 1'b0, "w8_aa_55");

        add_op(1, 16'h1, 16'h1, 16'h0, 1'b1, "w1_1_1");
        add_op(1, 16'h1, 16'h0, 16'h1, 1'b0, "w1_1_0");
        add_op(16, 16'h8000, 16'h8000, 16'h0000, 1'b1, "w16_8000_8000");
        add_op(16, 16'h1234, 16'h4321, 16'h5555, 1'b0, "w16_1234_4321");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial WIDTH-bit unsigned adder.
- Latches two operands on a start handshake, then presents one bit pair per cycle, LSB first, to an internal full adder.
- The full adder is built from two half_adder instances plus an OR gate, with a registered carry loop.
- Collects the sum bits into a result register and pulses done. This is the sequencing stage that feeds the half-adder datapath and consumes its sum/carry.

Parameters:
WIDTH, 8, operand and result width in bits; legal range 1..32.

Ports:
clk  input  1  single clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset; sampled on rising edge of clk
start  input  1  request to begin an addition; honoured only when ready=1
op_a  input  WIDTH  first operand; sampled in the cycle start is accepted
op_b  input  WIDTH  second operand; sampled in the cycle start is accepted
ready  output  1  high when idle and able to accept start
busy  output  1  high while bits are being processed
done  output  1  one-cycle pulse; result and carry_out valid from this cycle on
result  output  WIDTH  (op_a + op_b) mod 2^WIDTH
carry_out  output  1  carry out of bit WIDTH-1

Behaviour:
- Reset (rst=1 at an edge): state=IDLE; ready=1; busy=0; done=0; result=0; carry_out=0; carry reg=0; bit counter=0.
  - rst has priority over every other input, including mid-operation.
  - An aborted addition produces no done pulse.
- States are IDLE, SHIFT and DONE.
- IDLE:
  - ready=1, busy=0, done=0.
  - On start=1: load op_a/op_b into shift regs, clear carry reg, clear counter, go to SHIFT.
  - result and carry_out keep their previous values until the first SHIFT edge.
- SHIFT (busy=1, ready=0), each cycle:
  - a_bit = a_sh[0], b_bit = b_sh[0].
  - Full adder via two half_adders: s = a_bit^b_bit^c; c_next = (a_bit&b_bit) | (c&(a_bit^b_bit)).
  - Shift s into result from the MSB side (result <= {s, result[WIDTH-1:1]}).
  - Shift a_sh and b_sh right by 1; c <= c_next; counter++.
  - When counter reaches WIDTH-1 in this cycle: carry_out <= c_next, go to DONE.
  - The SHIFT state lasts exactly WIDTH cycles.
- DONE (one cycle): done=1, busy=0, ready=0; go to IDLE.
- Latency: start accepted at edge N, first SHIFT cycle is N+1, done is high during cycle N+WIDTH+1, and ready returns at N+WIDTH+2.
- Throughput: one addition per WIDTH+2 cycles.
- start while busy or in DONE: ignored, not queued; operand regs unchanged.
- Operands change after acceptance: no effect (captured at start).
- WIDTH=1: single SHIFT cycle; result=a^b, carry_out=a&b.
- result and carry_out are stable between done and the next accepted start plus one cycle.
- Counter width: clog2(WIDTH)+1 bits. The counter does not wrap inside an operation.

Test Plan:
- WIDTH=8, op_a=0x3C, op_b=0x0F, start pulse -> done high exactly 9 cycles after the accept edge (at cycle N+WIDTH+1); result=0x4B, carry_out=0; busy high for 8 cycles.
- WIDTH=8, 0xFF+0x01 -> result=0x00, carry_out=1. Then 0xFF+0xFF -> result=0xFE, carry_out=1. Then 0x00+0x00 -> result=0x00, carry_out=0.
- Start at accept, then start=1 with op_a=0x11, op_b=0x22 on every cycle while busy and in DONE -> exactly one done pulse per accept; first result matches the first operands (0x12+0x34=0x46); the second accept occurs only when ready=1.
- Reset mid-op: start 0xAA+0x55, assert rst for 1 cycle on the 4th SHIFT cycle -> next cycle ready=1, busy=0, result=0, carry_out=0; no done pulse follows.
- Back-to-back: start held high continuously -> accepts spaced exactly 10 cycles apart (WIDTH+2); each done's result equals the sum of the operands present at its accept edge.
- Parameter sweep: WIDTH=1 (1+1 -> result=0, carry_out=1, done at N+2) and WIDTH=16 (0x8000+0x8000 -> result=0x0000, carry_out=1, done at N+17).
